// File: rtl/plab5_mcore_mem_net_out_queue_pkg.sv
// Shared defaults and helpers for the domain-tagged memory-network output queue.
package plab5_mcore_mem_net_out_queue_pkg;

   localparam int unsigned DFLT_CTRL_NBITS   = 45;
   localparam int unsigned DFLT_DATA_NBITS   = 32;
   localparam int unsigned DFLT_NUM_ENTRIES  = 2;
   localparam int unsigned RESP_CTRL_NBITS   = 13;

   localparam logic DOMAIN_L = 1'b0;
   localparam logic DOMAIN_H = 1'b1;

   function automatic bit is_pow2(input int unsigned n);
      return (n >= 2) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/plab5_mcore_mem_net_out_queue_ctrl.sv
// Queue bookkeeping: pointers, occupancy count, ready/valid, and the
// enqueue/dequeue/scrub write enables for the storage in the top level.
module plab5_mcore_MemNetOutQueueCtrl
   import plab5_mcore_mem_net_out_queue_pkg::*;
#(
   parameter  int unsigned p_num_entries = DFLT_NUM_ENTRIES,
   localparam int unsigned AW            = $clog2(p_num_entries),
   localparam int unsigned CW            = AW + 1
)(
   input  logic          clk,
   input  logic          reset,
   input  logic          in_val,
   input  logic          out_rdy,
   output logic          in_rdy,
   output logic          out_val,
   output logic          enq_en,
   output logic          deq_en,
   output logic          scrub_en,
   output logic [AW-1:0] enq_ptr,
   output logic [AW-1:0] deq_ptr,
   output logic [AW-1:0] scrub_ptr
);

   localparam logic [CW-1:0] FULL_COUNT = CW'(p_num_entries);
   localparam logic [AW-1:0] LAST_PTR   = AW'(p_num_entries - 1);

   logic [CW-1:0] count;

   // Full/empty come only from count, never from pointer comparison.
   assign in_rdy    = (count != FULL_COUNT);
   assign out_val   = (count != '0);
   assign enq_en    = in_val & in_rdy;
   assign deq_en    = out_val & out_rdy;
   assign scrub_en  = deq_en;
   assign scrub_ptr = deq_ptr;

   always_ff @(posedge clk) begin
      if (reset) begin
         enq_ptr <= '0;
         deq_ptr <= '0;
         count   <= '0;
      end else begin
         if (enq_en)
            enq_ptr <= (enq_ptr == LAST_PTR) ? '0 : enq_ptr + AW'(1);
         if (deq_en)
            deq_ptr <= (deq_ptr == LAST_PTR) ? '0 : deq_ptr + AW'(1);
         case ({enq_en, deq_en})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/plab5_mcore_mem_net_out_queue.sv
// Domain-tagged circular buffer between a memory-network port and a cache bank.
// Data and domain slots are scrubbed as entries leave so no secret data lingers.
module plab5_mcore_mem_net_out_queue
   import plab5_mcore_mem_net_out_queue_pkg::*;
#(
   parameter int unsigned p_ctrl_nbits  = DFLT_CTRL_NBITS,
   parameter int unsigned p_data_nbits  = DFLT_DATA_NBITS,
   parameter int unsigned p_num_entries = DFLT_NUM_ENTRIES
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic [p_ctrl_nbits-1:0] in_msg_control,
   input  logic [p_data_nbits-1:0] in_msg_data,
   input  logic                    in_val,
   output logic                    in_rdy,
   input  logic                    in_domain,
   output logic [p_ctrl_nbits-1:0] out_msg_control,
   output logic [p_data_nbits-1:0] out_msg_data,
   output logic                    out_val,
   input  logic                    out_rdy,
   output logic                    out_domain
);

   localparam int unsigned AW = $clog2(p_num_entries);

   if (!is_pow2(p_num_entries)) begin : g_bad_depth
      $error("p_num_entries must be a power of two and at least 2");
   end

   logic                    enq_en;
   logic                    deq_en;
   logic                    scrub_en;
   logic [AW-1:0]           enq_ptr;
   logic [AW-1:0]           deq_ptr;
   logic [AW-1:0]           scrub_ptr;

   logic [p_ctrl_nbits-1:0] ctrl_mem [p_num_entries];
   logic [p_data_nbits-1:0] data_mem [p_num_entries];
   logic                    dom_mem  [p_num_entries];

   plab5_mcore_MemNetOutQueueCtrl #(
      .p_num_entries (p_num_entries)
   ) ctrl (
      .clk       (clk),
      .reset     (reset),
      .in_val    (in_val),
      .out_rdy   (out_rdy),
      .in_rdy    (in_rdy),
      .out_val   (out_val),
      .enq_en    (enq_en),
      .deq_en    (deq_en),
      .scrub_en  (scrub_en),
      .enq_ptr   (enq_ptr),
      .deq_ptr   (deq_ptr),
      .scrub_ptr (scrub_ptr)
   );

   // Enqueue takes priority over scrub if both target the same slot on one edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(p_num_entries); i++) begin
            ctrl_mem[i] <= '0;
            data_mem[i] <= '0;
            dom_mem[i]  <= DOMAIN_L;
         end
      end else begin
         for (int i = 0; i < int'(p_num_entries); i++) begin
            if (enq_en && (enq_ptr == AW'(i))) begin
               ctrl_mem[i] <= in_msg_control;
               data_mem[i] <= in_msg_data;
               dom_mem[i]  <= in_domain;
            end else if (scrub_en && (scrub_ptr == AW'(i))) begin
               data_mem[i] <= '0;
               dom_mem[i]  <= DOMAIN_L;
            end
         end
      end
   end

   // Nothing from a slot is visible unless the queue holds an entry.
   always_comb begin
      out_msg_control = '0;
      out_msg_data    = '0;
      out_domain      = DOMAIN_L;
      if (out_val) begin
         out_msg_control = ctrl_mem[deq_ptr];
         out_msg_data    = data_mem[deq_ptr];
         out_domain      = dom_mem[deq_ptr];
      end
   end

endmodule

// File: tb/tb_plab5_mcore_mem_net_out_queue.sv
// Self-checking bench: directed scenarios plus random traffic against a queue model.
module tb_plab5_mcore_mem_net_out_queue;

   localparam int CW = 45;
   localparam int DW = 32;
   localparam int N  = 2;

   typedef struct packed {
      logic          dom;
      logic [CW-1:0] ctrl;
      logic [DW-1:0] data;
   } entry_t;

   logic          clk = 1'b0;
   logic          reset;
   logic [CW-1:0] in_msg_control;
   logic [DW-1:0] in_msg_data;
   logic          in_val;
   logic          in_rdy;
   logic          in_domain;
   logic [CW-1:0] out_msg_control;
   logic [DW-1:0] out_msg_data;
   logic          out_val;
   logic          out_rdy;
   logic          out_domain;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   entry_t        model_q[$];
   logic [DW-1:0] rx[$];

   plab5_mcore_mem_net_out_queue #(
      .p_ctrl_nbits  (CW),
      .p_data_nbits  (DW),
      .p_num_entries (N)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .in_msg_control  (in_msg_control),
      .in_msg_data     (in_msg_data),
      .in_val          (in_val),
      .in_rdy          (in_rdy),
      .in_domain       (in_domain),
      .out_msg_control (out_msg_control),
      .out_msg_data    (out_msg_data),
      .out_val         (out_val),
      .out_rdy         (out_rdy),
      .out_domain      (out_domain)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a plain FIFO of bounded size, updated from the sampled inputs.
   always @(posedge clk) begin
      if (reset) begin
         model_q.delete();
      end else begin
         automatic bit do_deq = (model_q.size() != 0) && out_rdy;
         automatic bit do_enq = in_val && (model_q.size() < N);
         if (do_deq) void'(model_q.pop_front());
         if (do_enq) model_q.push_back({in_domain, in_msg_control, in_msg_data});
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         automatic entry_t head = '0;
         if (model_q.size() != 0) head = model_q[0];
         chk("in_rdy",   64'(in_rdy),          64'(model_q.size() != N));
         chk("out_val",  64'(out_val),         64'(model_q.size() != 0));
         chk("out_ctrl", 64'(out_msg_control), 64'(head.ctrl));
         chk("out_data", 64'(out_msg_data),    64'(head.data));
         chk("out_dom",  64'(out_domain),      64'(head.dom));
         if (out_val && out_rdy && !reset) rx.push_back(out_msg_data);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic enq(input logic dom, input logic [CW-1:0] c, input logic [DW-1:0] d);
      in_val = 1'b1; in_domain = dom; in_msg_control = c; in_msg_data = d;
   endtask

   initial begin
      reset = 1'b1; in_val = 1'b0; out_rdy = 1'b0;
      in_domain = 1'b0; in_msg_control = '0; in_msg_data = '0;
      step();
      chk_en = 1'b1;
      step();
      reset = 1'b0;

      // Idle after reset
      for (int i = 0; i < 5; i++) begin
         step();
         chk("idle_in_rdy",  64'(in_rdy), 64'd1);
         chk("idle_out_val", 64'(out_val), 64'd0);
         chk("idle_data",    64'(out_msg_data), 64'd0);
         chk("idle_ctrl",    64'(out_msg_control), 64'd0);
         chk("idle_dom",     64'(out_domain), 64'd0);
      end

      // Single enqueue then dequeue with scrub
      enq(1'b1, 45'h1_2345, 32'hDEAD_BEEF);
      step();
      in_val = 1'b0;
      chk("one_val",  64'(out_val), 64'd1);
      chk("one_dom",  64'(out_domain), 64'd1);
      chk("one_data", 64'(out_msg_data), 64'hDEAD_BEEF);
      chk("one_ctrl", 64'(out_msg_control), 64'h1_2345);
      out_rdy = 1'b1;
      step();
      out_rdy = 1'b0;
      chk("scrub_val",  64'(out_val), 64'd0);
      chk("scrub_data", 64'(out_msg_data), 64'd0);
      chk("scrub_slot", 64'(dut.data_mem[0]), 64'd0);
      chk("scrub_dom",  64'(dut.dom_mem[0]), 64'd0);

      // Fill, drop third, drain in order
      enq(1'b0, 45'h11, 32'hA1);
      step();
      enq(1'b1, 45'h22, 32'hA2);
      step();
      chk("full_in_rdy", 64'(in_rdy), 64'd0);
      enq(1'b0, 45'h33, 32'hA3);
      step();
      in_val = 1'b0;
      out_rdy = 1'b1;
      chk("drain0_dom",  64'(out_domain), 64'd0);
      chk("drain0_data", 64'(out_msg_data), 64'hA1);
      step();
      chk("drain1_dom",  64'(out_domain), 64'd1);
      chk("drain1_data", 64'(out_msg_data), 64'hA2);
      step();
      chk("drain_empty", 64'(out_val), 64'd0);
      out_rdy = 1'b0;

      // Full with simultaneous in_val and out_rdy
      enq(1'b0, 45'h1, 32'hB1);
      step();
      enq(1'b1, 45'h2, 32'hB2);
      step();
      enq(1'b0, 45'h3, 32'hB3);
      out_rdy = 1'b1;
      step();
      in_val = 1'b0;
      out_rdy = 1'b0;
      chk("fullboth_val",  64'(out_val), 64'd1);
      chk("fullboth_rdy",  64'(in_rdy), 64'd1);
      chk("fullboth_head", 64'(out_msg_data), 64'hB2);
      out_rdy = 1'b1;
      step();
      chk("fullboth_cnt1", 64'(out_val), 64'd0);
      out_rdy = 1'b0;

      // Steady stream of 16
      rx.delete();
      out_rdy = 1'b1;
      for (int i = 0; i < 16; i++) begin
         enq(1'(i), 45'(i), 32'(i));
         step();
      end
      in_val = 1'b0;
      step();
      step();
      chk("stream_len", 64'(rx.size()), 64'd16);
      for (int i = 0; i < 16 && i < rx.size(); i++)
         chk("stream_data", 64'(rx[i]), 64'(i));
      out_rdy = 1'b0;

      // Reset mid-traffic discards held entries
      enq(1'b1, 45'h77, 32'hC1);
      step();
      enq(1'b1, 45'h78, 32'hC2);
      step();
      in_val = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rst_out_val", 64'(out_val), 64'd0);
      chk("rst_in_rdy",  64'(in_rdy), 64'd1);
      rx.delete();
      out_rdy = 1'b1;
      for (int i = 0; i < 4; i++) step();
      chk("rst_no_old", 64'(rx.size()), 64'd0);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         in_val         = 1'($urandom);
         out_rdy        = 1'($urandom);
         in_domain      = 1'($urandom);
         in_msg_control = {13'($urandom), 32'($urandom)};
         in_msg_data    = 32'($urandom);
         reset          = ($urandom_range(0, 249) == 0);
         step();
      end
      reset = 1'b0; in_val = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
